// File: rtl/bus_control_sequencer_if.sv
// CPU-side bus of the PIC bus sequencer.
// Carries the strobes, A0, write data, read data and the tristate drive enable.
interface bus_control_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  chip_select_n;
    logic                  read_enable_n;
    logic                  write_enable_n;
    logic                  address;
    logic [DATA_WIDTH-1:0] data_bus_in;
    logic [DATA_WIDTH-1:0] data_bus_out;
    logic                  data_bus_out_enable;

    modport master (
        output chip_select_n,
        output read_enable_n,
        output write_enable_n,
        output address,
        output data_bus_in,
        input  data_bus_out,
        input  data_bus_out_enable
    );

    modport slave (
        input  chip_select_n,
        input  read_enable_n,
        input  write_enable_n,
        input  address,
        input  data_bus_in,
        output data_bus_out,
        output data_bus_out_enable
    );
endinterface

// File: rtl/bus_control_sequencer.sv
// PIC bus interface: registers CPU strobes, sequences ICW1..ICW4, decodes OCW1..OCW3 into
// one-cycle write pulses and multiplexes IRR/ISR/IMR/poll word onto the read bus.
module bus_control_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter bit CASCADE_EN = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    bus_control_sequencer_if.slave bus,
    input  logic [DATA_WIDTH-1:0] irr,
    input  logic [DATA_WIDTH-1:0] isr,
    input  logic [DATA_WIDTH-1:0] imr,
    input  logic                  poll_valid,
    input  logic [2:0]            poll_level,
    output logic [DATA_WIDTH-1:0] command_data,
    output logic                  write_icw1,
    output logic                  write_icw2,
    output logic                  write_icw3,
    output logic                  write_icw4,
    output logic                  write_ocw1,
    output logic                  write_ocw2,
    output logic                  write_ocw3,
    output logic                  icw4_needed,
    output logic                  single_mode,
    output logic                  init_done,
    output logic                  read_isr_select,
    output logic                  poll_pending,
    output logic                  read_end,
    output logic                  protocol_error
);

    typedef enum logic [2:0] {
        ST_WAIT_ICW1 = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic                  wr_act_s;
    logic                  rd_act_s;
    logic                  overlap_s;
    logic                  commit_s;
    logic                  is_icw1_s;
    logic                  read_end_s;
    logic                  wr_q_r;
    logic                  rd_q_r;
    logic                  overlap_q_r;
    logic                  addr_q_r;
    logic [DATA_WIDTH-1:0] command_data_r;
    logic [3:0]            icw_pulse_s;
    logic [2:0]            ocw_pulse_s;
    logic                  decode_err_s;
    logic                  ic4_next_s;
    logic                  sngl_next_s;
    logic                  ris_next_s;
    logic                  poll_next_s;
    logic [3:0]            icw_pulse_r;
    logic [2:0]            ocw_pulse_r;
    logic                  ic4_r;
    logic                  sngl_r;
    logic                  ris_r;
    logic                  poll_r;
    logic                  err_r;
    logic                  init_done_r;
    logic [DATA_WIDTH-1:0] read_mux_s;
    logic [DATA_WIDTH-1:0] data_out_r;

    assign wr_act_s   = ~bus.write_enable_n & ~bus.chip_select_n;
    assign rd_act_s   = ~bus.read_enable_n & ~bus.chip_select_n;
    assign overlap_s  = wr_act_s & rd_act_s;
    assign commit_s   = wr_q_r & ~wr_act_s;
    assign read_end_s = rd_q_r & ~rd_act_s;
    assign is_icw1_s  = ~addr_q_r & command_data_r[4];

    // Strobe history and capture of the write data / A0 while the write strobe is held
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q_r         <= 1'b0;
            rd_q_r         <= 1'b0;
            overlap_q_r    <= 1'b0;
            addr_q_r       <= 1'b0;
            command_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_q_r      <= wr_act_s;
            rd_q_r      <= rd_act_s;
            overlap_q_r <= overlap_s;
            if (wr_act_s) begin
                command_data_r <= bus.data_bus_in;
                addr_q_r       <= bus.address;
            end
        end
    end

    // Command decode at the commit cycle: next state, pulse requests and latched mode flags
    always_comb begin
        state_next_s = state_r;
        icw_pulse_s  = 4'b0000;
        ocw_pulse_s  = 3'b000;
        decode_err_s = 1'b0;
        ic4_next_s   = ic4_r;
        sngl_next_s  = sngl_r;
        ris_next_s   = ris_r;
        poll_next_s  = poll_r & ~read_end_s;
        if (commit_s) begin
            if (is_icw1_s) begin
                // ICW1 restarts initialisation from any state
                icw_pulse_s[0] = 1'b1;
                state_next_s   = ST_WAIT_ICW2;
                ic4_next_s     = command_data_r[0];
                sngl_next_s    = command_data_r[1];
                ris_next_s     = 1'b0;
                poll_next_s    = 1'b0;
            end else begin
                case (state_r)
                    ST_WAIT_ICW1: begin
                        decode_err_s = 1'b1;
                    end
                    ST_WAIT_ICW2: begin
                        if (addr_q_r) begin
                            icw_pulse_s[1] = 1'b1;
                            if (CASCADE_EN && !sngl_r) begin
                                state_next_s = ST_WAIT_ICW3;
                            end else if (ic4_r) begin
                                state_next_s = ST_WAIT_ICW4;
                            end else begin
                                state_next_s = ST_READY;
                            end
                        end else begin
                            decode_err_s = 1'b1;
                        end
                    end
                    ST_WAIT_ICW3: begin
                        if (addr_q_r) begin
                            icw_pulse_s[2] = 1'b1;
                            state_next_s   = ic4_r ? ST_WAIT_ICW4 : ST_READY;
                        end else begin
                            decode_err_s = 1'b1;
                        end
                    end
                    ST_WAIT_ICW4: begin
                        if (addr_q_r) begin
                            icw_pulse_s[3] = 1'b1;
                            state_next_s   = ST_READY;
                        end else begin
                            decode_err_s = 1'b1;
                        end
                    end
                    ST_READY: begin
                        if (addr_q_r) begin
                            ocw_pulse_s[0] = 1'b1;
                        end else if (command_data_r[3]) begin
                            ocw_pulse_s[2] = 1'b1;
                            ris_next_s     = command_data_r[1] ? command_data_r[0] : ris_r;
                            poll_next_s    = poll_next_s | command_data_r[2];
                        end else begin
                            ocw_pulse_s[1] = 1'b1;
                        end
                    end
                    default: begin
                        state_next_s = ST_WAIT_ICW1;
                        decode_err_s = 1'b1;
                    end
                endcase
            end
        end else begin
            decode_err_s = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_WAIT_ICW1;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered pulses and flags; overlap error fires only on the first overlapping cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            icw_pulse_r <= 4'b0000;
            ocw_pulse_r <= 3'b000;
            ic4_r       <= 1'b0;
            sngl_r      <= 1'b0;
            ris_r       <= 1'b0;
            poll_r      <= 1'b0;
            err_r       <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            icw_pulse_r <= icw_pulse_s;
            ocw_pulse_r <= ocw_pulse_s;
            ic4_r       <= ic4_next_s;
            sngl_r      <= sngl_next_s;
            ris_r       <= ris_next_s;
            poll_r      <= poll_next_s;
            err_r       <= decode_err_s | (overlap_s & ~overlap_q_r);
            init_done_r <= (state_next_s == ST_READY);
        end
    end

    // Read source select; the poll word carries the valid flag in the MSB
    always_comb begin
        read_mux_s = {DATA_WIDTH{1'b0}};
        if (bus.address) begin
            read_mux_s = imr;
        end else if (poll_r) begin
            read_mux_s[DATA_WIDTH-1] = poll_valid;
            read_mux_s[2:0]          = poll_level;
        end else if (ris_r) begin
            read_mux_s = isr;
        end else begin
            read_mux_s = irr;
        end
    end

    // Read data register, refreshed on every cycle the read strobe is active
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_act_s) begin
            data_out_r <= read_mux_s;
        end
    end

    assign bus.data_bus_out        = data_out_r;
    assign bus.data_bus_out_enable = rd_q_r & ~wr_act_s;
    assign read_end                = read_end_s;
    assign command_data            = command_data_r;
    assign write_icw1              = icw_pulse_r[0];
    assign write_icw2              = icw_pulse_r[1];
    assign write_icw3              = icw_pulse_r[2];
    assign write_icw4              = icw_pulse_r[3];
    assign write_ocw1              = ocw_pulse_r[0];
    assign write_ocw2              = ocw_pulse_r[1];
    assign write_ocw3              = ocw_pulse_r[2];
    assign icw4_needed             = ic4_r;
    assign single_mode             = sngl_r;
    assign init_done               = init_done_r;
    assign read_isr_select         = ris_r;
    assign poll_pending            = poll_r;
    assign protocol_error          = err_r;

endmodule
